// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, instruction-memory
// wait handling, and saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int REG_WIDTH    = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic [REG_WIDTH-1:0] i_IFID_RS1,
  input  logic [REG_WIDTH-1:0] i_IFID_RS2,
  input  logic [REG_WIDTH-1:0] i_IDEX_RD,
  input  logic                 i_IDEX_MemRead,
  input  logic                 i_BranchTaken,
  input  logic                 i_IMemReady,
  input  logic                 i_CntClear,
  output logic                 o_PCStall,
  output logic                 o_IFIDStall,
  output logic                 o_IFIDFlush,
  output logic                 o_IDEXFlush,
  output logic                 o_FetchAbort,
  output logic [1:0]           o_State,
  output logic [CNT_WIDTH-1:0] o_StallCount,
  output logic [CNT_WIDTH-1:0] o_FlushCount
);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_FLUSH     = 2'd1,
    S_IMEM_WAIT = 2'd2
  } state_t;

  localparam bit                   MULTI_FLUSH  = (FLUSH_CYCLES > 1);
  localparam logic [2:0]           FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [2:0]             r_flush_cnt;
  logic [2:0]             w_next_flush_cnt;
  logic                   w_load_use;
  logic                   w_flush_event;
  logic [CNT_WIDTH-1:0]   r_stall_count;
  logic [CNT_WIDTH-1:0]   r_flush_count;

  assign w_load_use = i_IDEX_MemRead && (i_IDEX_RD != '0) &&
                      ((i_IDEX_RD == i_IFID_RS1) || (i_IDEX_RD == i_IFID_RS2));

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    w_next_state     = r_state;
    w_next_flush_cnt = r_flush_cnt;
    w_flush_event    = 1'b0;
    o_PCStall        = 1'b0;
    o_IFIDStall      = 1'b0;
    o_IFIDFlush      = 1'b0;
    o_IDEXFlush      = 1'b0;
    o_FetchAbort     = 1'b0;

    if (!i_Reset) begin
      // A taken branch wins in every legal state; it always restarts the flush window.
      if (i_BranchTaken && (r_state != 2'd3)) begin
        o_IFIDFlush      = 1'b1;
        o_IDEXFlush      = 1'b1;
        o_FetchAbort     = (r_state == S_IMEM_WAIT);
        w_flush_event    = 1'b1;
        w_next_state     = MULTI_FLUSH ? S_FLUSH : S_RUN;
        w_next_flush_cnt = MULTI_FLUSH ? FLUSH_RELOAD : 3'd0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (!i_IMemReady) begin
              o_PCStall    = 1'b1;
              o_IFIDFlush  = 1'b1;
              w_next_state = S_IMEM_WAIT;
            end else if (w_load_use) begin
              o_PCStall   = 1'b1;
              o_IFIDStall = 1'b1;
              o_IDEXFlush = 1'b1;
            end
          end
          S_FLUSH: begin
            o_IFIDFlush      = 1'b1;
            o_IDEXFlush      = 1'b1;
            w_next_flush_cnt = r_flush_cnt - 3'd1;
            if (r_flush_cnt == 3'd1) w_next_state = S_RUN;
          end
          S_IMEM_WAIT: begin
            if (i_IMemReady) begin
              w_next_state = S_RUN;
            end else begin
              o_PCStall   = 1'b1;
              o_IFIDFlush = 1'b1;
            end
          end
          default: begin
            w_next_state     = S_RUN;
            w_next_flush_cnt = 3'd0;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= S_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_flush_cnt;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else if (i_CntClear) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (o_PCStall && (r_stall_count != CNT_MAX))
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      if (w_flush_event && (r_flush_count != CNT_MAX))
        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
    end
  end

  assign o_State      = r_state;
  assign o_StallCount = r_stall_count;
  assign o_FlushCount = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: two instances (3-cycle flush with 4-bit counters, and
// defaults) driven together and compared against a behavioural model.
module tb_pipeline_ctrl;

  localparam int FC_A = 3;
  localparam int FC_B = 1;
  localparam int MAX_A = 15;
  localparam int MAX_B = 65535;

  localparam int M_RUN = 0, M_FLUSH = 1, M_WAIT = 2;
  localparam logic [4:0] B_PC = 5'b10000, B_IS = 5'b01000, B_IF = 5'b00100,
                         B_IX = 5'b00010, B_AB = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       memread = 1'b0, branch = 1'b0, ready = 1'b1, clr = 1'b0;

  logic       a_pc, a_is, a_if, a_ix, a_ab, b_pc, b_is, b_if, b_ix, b_ab;
  logic [1:0] a_st, b_st;
  logic [3:0] a_sc, a_fc;
  logic [15:0] b_sc, b_fc;

  logic [4:0]  dut_ctl[2];
  logic [1:0]  dut_st[2];
  logic [15:0] dut_sc[2];
  logic [15:0] dut_fc[2];

  int n_checks = 0;
  int n_errors = 0;

  int m_mode[2], m_left[2], m_sc[2], m_fc[2];
  int nx_mode[2], nx_left[2];
  logic [4:0] e_ctl[2];
  bit e_ev[2];
  logic [4:0] last_ctl[2];

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_WIDTH(5), .FLUSH_CYCLES(FC_A), .CNT_WIDTH(4)) dut_a (
    .i_Clock(clk), .i_Reset(rst), .i_IFID_RS1(rs1), .i_IFID_RS2(rs2),
    .i_IDEX_RD(rd), .i_IDEX_MemRead(memread), .i_BranchTaken(branch),
    .i_IMemReady(ready), .i_CntClear(clr), .o_PCStall(a_pc), .o_IFIDStall(a_is),
    .o_IFIDFlush(a_if), .o_IDEXFlush(a_ix), .o_FetchAbort(a_ab), .o_State(a_st),
    .o_StallCount(a_sc), .o_FlushCount(a_fc));

  pipeline_ctrl dut_b (
    .i_Clock(clk), .i_Reset(rst), .i_IFID_RS1(rs1), .i_IFID_RS2(rs2),
    .i_IDEX_RD(rd), .i_IDEX_MemRead(memread), .i_BranchTaken(branch),
    .i_IMemReady(ready), .i_CntClear(clr), .o_PCStall(b_pc), .o_IFIDStall(b_is),
    .o_IFIDFlush(b_if), .o_IDEXFlush(b_ix), .o_FetchAbort(b_ab), .o_State(b_st),
    .o_StallCount(b_sc), .o_FlushCount(b_fc));

  assign dut_ctl[0] = {a_pc, a_is, a_if, a_ix, a_ab};
  assign dut_ctl[1] = {b_pc, b_is, b_if, b_ix, b_ab};
  assign dut_st[0]  = a_st;
  assign dut_st[1]  = b_st;
  assign dut_sc[0]  = {12'b0, a_sc};
  assign dut_sc[1]  = b_sc;
  assign dut_fc[0]  = {12'b0, a_fc};
  assign dut_fc[1]  = b_fc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_RUN; m_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end
  endtask

  // Control outputs and next mode for one instance, straight from the rule table.
  task automatic model_eval(input int k, input logic br, input logic rdy, input logic lu);
    int fc;
    fc = (k == 0) ? FC_A : FC_B;
    e_ctl[k] = '0; e_ev[k] = 1'b0;
    nx_mode[k] = m_mode[k]; nx_left[k] = m_left[k];
    if (br) begin
      e_ctl[k]   = B_IF | B_IX | ((m_mode[k] == M_WAIT) ? B_AB : 5'b0);
      e_ev[k]    = 1'b1;
      nx_mode[k] = (fc > 1) ? M_FLUSH : M_RUN;
      nx_left[k] = fc - 1;
    end else if (m_mode[k] == M_RUN) begin
      if (!rdy) begin
        e_ctl[k] = B_PC | B_IF; nx_mode[k] = M_WAIT;
      end else if (lu) begin
        e_ctl[k] = B_PC | B_IS | B_IX;
      end
    end else if (m_mode[k] == M_FLUSH) begin
      e_ctl[k]   = B_IF | B_IX;
      nx_left[k] = m_left[k] - 1;
      if (nx_left[k] == 0) nx_mode[k] = M_RUN;
    end else begin
      if (rdy) nx_mode[k] = M_RUN;
      else     e_ctl[k] = B_PC | B_IF;
    end
  endtask

  task automatic model_commit(input int k, input logic c);
    int mx;
    mx = (k == 0) ? MAX_A : MAX_B;
    m_mode[k] = nx_mode[k]; m_left[k] = nx_left[k];
    if (c) begin
      m_sc[k] = 0; m_fc[k] = 0;
    end else begin
      if (e_ctl[k][4] && m_sc[k] < mx) m_sc[k]++;
      if (e_ev[k] && m_fc[k] < mx) m_fc[k]++;
    end
  endtask

  // One clock cycle: drive after the rising edge, check outputs at the falling
  // edge, check counters just after the next rising edge.
  task automatic step(input logic br, input logic rdy, input logic mr, input logic c,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    logic lu;
    branch = br; ready = rdy; memread = mr; clr = c; rd = d; rs1 = s1; rs2 = s2;
    lu = mr && (d != 0) && (d == s1 || d == s2);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model_eval(k, br, rdy, lu);
      last_ctl[k] = dut_ctl[k];
      check($sformatf("ctl[%0d]", k), {27'b0, dut_ctl[k]}, {27'b0, e_ctl[k]});
      check($sformatf("state[%0d]", k), {30'b0, dut_st[k]}, m_mode[k]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_commit(k, c);
      check($sformatf("stallcnt[%0d]", k), {16'b0, dut_sc[k]}, m_sc[k]);
      check($sformatf("flushcnt[%0d]", k), {16'b0, dut_fc[k]}, m_fc[k]);
    end
  endtask

  task automatic idle(input logic c);
    step(1'b0, 1'b1, 1'b0, c, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    model_reset();
    branch = 1'b1; ready = 1'b0; memread = 1'b1; rd = 5'd3; rs1 = 5'd3;
    #12;
    check("reset_ctl_a", {27'b0, dut_ctl[0]}, 32'd0);
    check("reset_ctl_b", {27'b0, dut_ctl[1]}, 32'd0);
    check("reset_state_a", {30'b0, a_st}, 32'd0);
    check("reset_cnt_a", {24'b0, a_sc, a_fc}, 32'd0);
    check("reset_cnt_b", {b_sc, b_fc}, 32'd0);
    branch = 1'b0; ready = 1'b1; memread = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Load-use hazard, then the same with RD=0.
    idle(1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd0);
    check("loaduse_ctl", {27'b0, last_ctl[0]}, {27'b0, B_PC | B_IS | B_IX});
    check("loaduse_sc", {28'b0, a_sc}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
    check("rd0_ctl", {27'b0, last_ctl[0]}, 32'd0);

    // Taken branch: three flush cycles on instance A.
    idle(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(1'b0);
    idle(1'b0);
    check("branch_last_flush", {27'b0, last_ctl[0]}, {27'b0, B_IF | B_IX});
    idle(1'b0);
    check("branch_end_ctl", {27'b0, last_ctl[0]}, 32'd0);
    check("branch_fc_a", {28'b0, a_fc}, 32'd1);
    check("branch_fc_b", {16'b0, b_fc}, 32'd1);

    // Memory wait of four cycles.
    idle(1'b1);
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(1'b0);
    check("memwait_ready_ctl", {27'b0, last_ctl[0]}, 32'd0);
    check("memwait_sc", {28'b0, a_sc}, 32'd4);

    // Branch during the wait with memory ready: abort wins.
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("abort_ctl_a", {27'b0, last_ctl[0]}, {27'b0, B_IF | B_IX | B_AB});
    check("abort_ctl_b", {27'b0, last_ctl[1]}, {27'b0, B_IF | B_IX | B_AB});
    repeat (3) idle(1'b0);

    // Saturation of the 4-bit counter, then clear beats increment.
    idle(1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("sat_sc_a", {28'b0, a_sc}, 32'd15);
    check("sat_sc_b", {16'b0, b_sc}, 32'd20);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
    check("clear_sc_a", {28'b0, a_sc}, 32'd0);
    check("clear_sc_b", {16'b0, b_sc}, 32'd0);
    idle(1'b0);

    // Asynchronous reset between edges while instance A is flushing.
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    check("pre_reset_state", {30'b0, a_st}, 32'd1);
    branch = 1'b1; ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("areset_state", {30'b0, a_st}, 32'd0);
    check("areset_cnt_a", {24'b0, a_sc, a_fc}, 32'd0);
    check("areset_cnt_b", {b_sc, b_fc}, 32'd0);
    check("areset_ctl_a", {27'b0, dut_ctl[0]}, 32'd0);
    check("areset_ctl_b", {27'b0, dut_ctl[1]}, 32'd0);
    branch = 1'b0; ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    idle(1'b0);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 8) == 0, ($urandom % 4) != 0, $urandom % 2,
           ($urandom % 40) == 0, 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
